// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter: per-requester FIFOs, round-robin grant, registered RF write port.
// Optional macro RFA_R0_DISCARD_EN: requests to register 0 are accepted but dropped.
module rf_write_arbiter #(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [2:0]  req0_addr,
   input  logic [15:0] req0_data,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [2:0]  req1_addr,
   input  logic [15:0] req1_data,
   output logic        rf_we,
   output logic [2:0]  rf_a3,
   output logic [15:0] rf_wd,
   output logic [7:0]  pending,
   output logic        idle
);

   localparam int unsigned AW = 3;
   localparam int unsigned DW = 16;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0] r_addr [2][FIFO_DEPTH];
   logic [DW-1:0] r_data [2][FIFO_DEPTH];
   logic [PW-1:0] r_wptr [2];
   logic [PW-1:0] r_rptr [2];
   logic [CW-1:0] r_cnt  [2];
   logic          r_last;

   logic [1:0]    w_valid;
   logic [1:0]    w_ready;
   logic [1:0]    w_push;
   logic [1:0]    w_pop;
   logic [1:0]    w_nonempty;
   logic [AW-1:0] w_in_addr [2];
   logic [DW-1:0] w_in_data [2];
   logic          w_gnt_any;
   logic          w_gnt_id;
   logic [PW-1:0] w_off;

   // Handshake, push qualification and round-robin grant
   always_comb begin
      w_valid      = {req1_valid, req0_valid};
      w_in_addr[0] = req0_addr;
      w_in_addr[1] = req1_addr;
      w_in_data[0] = req0_data;
      w_in_data[1] = req1_data;
      for (int unsigned k = 0; k < 2; k++) begin
         w_ready[k]    = (r_cnt[k] != CW'(FIFO_DEPTH));
         w_nonempty[k] = (r_cnt[k] != '0);
`ifdef RFA_R0_DISCARD_EN
         w_push[k]     = w_valid[k] & w_ready[k] & (w_in_addr[k] != '0);
`else
         w_push[k]     = w_valid[k] & w_ready[k];
`endif
      end
      w_gnt_any = |w_nonempty;
      w_gnt_id  = (&w_nonempty) ? ~r_last : ~w_nonempty[0];
      w_pop     = w_gnt_any ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;
   end

   assign req0_ready = w_ready[0];
   assign req1_ready = w_ready[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < 2; k++) begin
            r_wptr[k] <= '0;
            r_rptr[k] <= '0;
            r_cnt[k]  <= '0;
         end
         r_last <= 1'b1;
         rf_we  <= 1'b0;
         rf_a3  <= '0;
         rf_wd  <= '0;
      end else begin
         for (int unsigned k = 0; k < 2; k++) begin
            if (w_push[k]) begin
               r_addr[k][r_wptr[k]] <= w_in_addr[k];
               r_data[k][r_wptr[k]] <= w_in_data[k];
               r_wptr[k]            <= r_wptr[k] + PW'(1);
            end
            if (w_pop[k]) begin
               r_rptr[k] <= r_rptr[k] + PW'(1);
            end
            case ({w_push[k], w_pop[k]})
               2'b10:   r_cnt[k] <= r_cnt[k] + CW'(1);
               2'b01:   r_cnt[k] <= r_cnt[k] - CW'(1);
               default: r_cnt[k] <= r_cnt[k];
            endcase
         end
         rf_we <= w_gnt_any;
         if (w_gnt_any) begin
            rf_a3  <= r_addr[w_gnt_id][r_rptr[w_gnt_id]];
            rf_wd  <= r_data[w_gnt_id][r_rptr[w_gnt_id]];
            r_last <= w_gnt_id;
         end
      end
   end

   // Scoreboard of destinations still owed a write: live queue slots plus the output stage
   always_comb begin
      pending = '0;
      w_off   = '0;
      for (int unsigned k = 0; k < 2; k++) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            w_off = PW'(i) - r_rptr[k];
            if (CW'(w_off) < r_cnt[k]) begin
               pending = pending | (8'(1) << r_addr[k][i]);
            end
         end
      end
      if (rf_we) begin
         pending = pending | (8'(1) << rf_a3);
      end
   end

   assign idle = ~w_nonempty[0] & ~w_nonempty[1] & ~rf_we;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: queue-level reference model compared every cycle plus directed literal checks.
module tb_rf_write_arbiter;

   localparam int D = 2;

   logic        clk;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [2:0]  req0_addr, req1_addr;
   logic [15:0] req0_data, req1_data;
   logic        rf_we;
   logic [2:0]  rf_a3;
   logic [15:0] rf_wd;
   logic [7:0]  pending;
   logic        idle;

   rf_write_arbiter #(.FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
      .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .pending(pending), .idle(idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  a;
      logic [15:0] d;
   } ent_t;

   ent_t        mq0[$];
   ent_t        mq1[$];
   bit          m_last;
   logic        m_we;
   logic [2:0]  m_a3;
   logic [15:0] m_wd;

   int n_tot  = 0;
   int n_pass = 0;

   // Reference model: queues of pending writes, oldest first
   always @(posedge clk) begin
      bit   rdy0, rdy1, have_g;
      int   g;
      ent_t e;
      if (rst) begin
         mq0.delete();
         mq1.delete();
         m_we   = 1'b0;
         m_a3   = '0;
         m_wd   = '0;
         m_last = 1'b1;
      end else begin
         rdy0   = mq0.size() < D;
         rdy1   = mq1.size() < D;
         have_g = 1'b1;
         g      = 0;
         if (mq0.size() > 0 && mq1.size() > 0) g = m_last ? 0 : 1;
         else if (mq0.size() > 0)              g = 0;
         else if (mq1.size() > 0)              g = 1;
         else                                  have_g = 1'b0;
         m_we = have_g;
         if (have_g) begin
            e      = (g == 0) ? mq0.pop_front() : mq1.pop_front();
            m_a3   = e.a;
            m_wd   = e.d;
            m_last = (g == 1);
         end
`ifdef RFA_R0_DISCARD_EN
         if (req0_valid && rdy0 && req0_addr != 3'd0) mq0.push_back('{req0_addr, req0_data});
         if (req1_valid && rdy1 && req1_addr != 3'd0) mq1.push_back('{req1_addr, req1_data});
`else
         if (req0_valid && rdy0) mq0.push_back('{req0_addr, req0_data});
         if (req1_valid && rdy1) mq1.push_back('{req1_addr, req1_data});
`endif
      end
   end

   function automatic logic [7:0] model_pending();
      logic [7:0] p = '0;
      foreach (mq0[i]) p[mq0[i].a] = 1'b1;
      foreach (mq1[i]) p[mq1[i].a] = 1'b1;
      if (m_we) p[m_a3] = 1'b1;
      return p;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic compare_model();
      chk("m_req0_ready", 32'(req0_ready), 32'(mq0.size() < D));
      chk("m_req1_ready", 32'(req1_ready), 32'(mq1.size() < D));
      chk("m_rf_we",      32'(rf_we),      32'(m_we));
      chk("m_rf_a3",      32'(rf_a3),      32'(m_a3));
      chk("m_rf_wd",      32'(rf_wd),      32'(m_wd));
      chk("m_pending",    32'(pending),    32'(model_pending()));
      chk("m_idle",       32'(idle),       32'(mq0.size() == 0 && mq1.size() == 0 && !m_we));
   endtask

   // One clock: let the edge happen, then compare at the following negedge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      compare_model();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      bit         seen_nr;
      bit         acc0, acc1;
      int         i0, j1, cyc;
      logic [15:0] got[$];

      rst = 1'b1;
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      @(negedge clk);
      tick();
      do_reset();
      chk("rst_ready0", 32'(req0_ready), 32'd1);
      chk("rst_ready1", 32'(req1_ready), 32'd1);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_idle", 32'(idle), 32'd1);
      chk("rst_we", 32'(rf_we), 32'd0);

      // Single uncontended write
      req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 16'h1234;
      tick();
      req0_valid = 1'b0;
      chk("t1_pend_e0", 32'(pending), 32'h08);
      chk("t1_we_e0", 32'(rf_we), 32'd0);
      tick();
      chk("t1_we", 32'(rf_we), 32'd1);
      chk("t1_a3", 32'(rf_a3), 32'd3);
      chk("t1_wd", 32'(rf_wd), 32'h1234);
      chk("t1_pend_e1", 32'(pending), 32'h08);
      tick();
      chk("t1_we_off", 32'(rf_we), 32'd0);
      chk("t1_pend_off", 32'(pending), 32'd0);
      chk("t1_idle", 32'(idle), 32'd1);

      // Simultaneous acceptance after reset: requester 0 first
      do_reset();
      req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'hAAAA;
      req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 16'hBBBB;
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("t2_pend", 32'(pending), 32'h06);
      tick();
      chk("t2_first_a3", 32'(rf_a3), 32'd1);
      chk("t2_first_wd", 32'(rf_wd), 32'hAAAA);
      tick();
      chk("t2_second_we", 32'(rf_we), 32'd1);
      chk("t2_second_a3", 32'(rf_a3), 32'd2);
      chk("t2_second_wd", 32'(rf_wd), 32'hBBBB);
      tick();
      chk("t2_done", 32'(rf_we), 32'd0);

      // Both streaming: req1 backpressured, its 4 words arrive in order
      do_reset();
      seen_nr = 1'b0; i0 = 0; j1 = 0; cyc = 0;
      got.delete();
      while (got.size() < 4 && cyc < 60) begin
         req0_valid = (i0 < 10);
         req0_addr  = 3'(1 + i0 % 3);
         req0_data  = 16'hA000 + 16'(i0);
         req1_valid = (j1 < 4);
         req1_addr  = 3'(4 + j1);
         req1_data  = 16'hB000 + 16'(j1);
         if (req1_valid && !req1_ready) seen_nr = 1'b1;
         acc0 = req0_valid && req0_ready;
         acc1 = req1_valid && req1_ready;
         tick();
         if (acc0) i0++;
         if (acc1) j1++;
         if (rf_we && rf_a3 >= 3'd4) got.push_back(rf_wd);
         cyc++;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("t3_seen_not_ready", 32'(seen_nr), 32'd1);
      chk("t3_count", 32'(got.size()), 32'd4);
      for (int k = 0; k < 4 && k < got.size(); k++)
         chk("t3_order", 32'(got[k]), 32'hB000 + 32'(k));
      for (int k = 0; k < 12; k++) tick();
      chk("t3_drained", 32'(idle), 32'd1);

      // Reset with queued and in-flight writes discards them
      do_reset();
      for (int k = 0; k < 4; k++) begin
         req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 16'hC000 + 16'(k);
         req1_valid = 1'b1; req1_addr = 3'd6; req1_data = 16'hD000 + 16'(k);
         tick();
      end
      chk("t4_busy", 32'(idle), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      chk("t4_we", 32'(rf_we), 32'd0);
      chk("t4_pend", 32'(pending), 32'd0);
      chk("t4_idle", 32'(idle), 32'd1);
      chk("t4_ready0", 32'(req0_ready), 32'd1);
      chk("t4_ready1", 32'(req1_ready), 32'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t4_no_write", 32'(rf_we), 32'd0);
      end

      // Register-0 request
      req0_valid = 1'b1; req0_addr = 3'd0; req0_data = 16'hFFFF;
      chk("t5_ready", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      tick();
`ifdef RFA_R0_DISCARD_EN
      chk("t5_we", 32'(rf_we), 32'd0);
      chk("t5_idle", 32'(idle), 32'd1);
      chk("t5_pend", 32'(pending), 32'd0);
`else
      chk("t5_we", 32'(rf_we), 32'd1);
      chk("t5_a3", 32'(rf_a3), 32'd0);
      chk("t5_wd", 32'(rf_wd), 32'hFFFF);
      chk("t5_pend", 32'(pending), 32'h01);
`endif
      tick();
      chk("t5_end_idle", 32'(idle), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
